// File: rtl/lcd_nibble_writer.sv
// rtl/lcd_nibble_writer.sv - 4-bit LCD bus transmitter: two E-strobed nibbles per word, then execution wait
module lcd_nibble_writer #(
    parameter int T_SETUP = 2,
    parameter int T_E     = 12,
    parameter int T_HOLD  = 1,
    parameter int T_GAP   = 50,
    parameter int T_SHORT = 2000,
    parameter int T_LONG  = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       done,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       SF_D11,
    output logic       SF_D10,
    output logic       SF_D9,
    output logic       SF_D8
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_U_SETUP,
        S_U_EN,
        S_U_HOLD,
        S_GAP,
        S_L_SETUP,
        S_L_EN,
        S_L_HOLD,
        S_WAIT
    } state_t;

    // Counter reload values: a state lasting N cycles counts N-1 down to 0.
    localparam logic [16:0] C_SETUP = 17'(T_SETUP - 1);
    localparam logic [16:0] C_E     = 17'(T_E - 1);
    localparam logic [16:0] C_HOLD  = 17'(T_HOLD - 1);
    localparam logic [16:0] C_GAP   = 17'(T_GAP - 1);
    localparam logic [16:0] C_SHORT = 17'(T_SHORT - 1);
    localparam logic [16:0] C_LONG  = 17'(T_LONG - 1);

    state_t      r_state;
    logic [16:0] r_cnt;
    logic        r_rs;
    logic [7:0]  r_d;
    logic        r_done;

    state_t      w_next_state;
    logic [16:0] w_next_cnt;
    logic        w_accept;
    logic        w_done_next;
    logic        w_expire;
    logic        w_long;
    logic [3:0]  w_nibble;
    logic        w_unused_rw;

    // The RW bit is accepted but meaningless: this block only ever writes.
    assign w_unused_rw = cmd_data[8];
    assign w_expire    = (r_cnt == 17'd0);
    // Clear display and return home need the long execution time.
    assign w_long      = !r_rs && (r_d[7:2] == 6'd0) && (r_d[1:0] != 2'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 17'd0;
            r_rs    <= 1'b0;
            r_d     <= 8'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_done  <= w_done_next;
            if (w_accept) begin
                r_rs <= cmd_data[9];
                r_d  <= cmd_data[7:0];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = w_expire ? 17'd0 : (r_cnt - 17'd1);
        w_accept     = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_U_SETUP;
                    w_next_cnt   = C_SETUP;
                end
            end
            S_U_SETUP: if (w_expire) begin
                w_next_state = S_U_EN;
                w_next_cnt   = C_E;
            end
            S_U_EN: if (w_expire) begin
                w_next_state = S_U_HOLD;
                w_next_cnt   = C_HOLD;
            end
            S_U_HOLD: if (w_expire) begin
                w_next_state = S_GAP;
                w_next_cnt   = C_GAP;
            end
            S_GAP: if (w_expire) begin
                w_next_state = S_L_SETUP;
                w_next_cnt   = C_SETUP;
            end
            S_L_SETUP: if (w_expire) begin
                w_next_state = S_L_EN;
                w_next_cnt   = C_E;
            end
            S_L_EN: if (w_expire) begin
                w_next_state = S_L_HOLD;
                w_next_cnt   = C_HOLD;
            end
            S_L_HOLD: if (w_expire) begin
                w_next_state = S_WAIT;
                w_next_cnt   = w_long ? C_LONG : C_SHORT;
            end
            S_WAIT: if (w_expire) begin
                w_next_state = S_IDLE;
                w_next_cnt   = 17'd0;
                w_done_next  = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 17'd0;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        done      = r_done;
        LCD_RW    = 1'b0;
        LCD_E     = (r_state == S_U_EN) || (r_state == S_L_EN);
        LCD_RS    = 1'b0;
        w_nibble  = 4'b0000;
        case (r_state)
            S_U_SETUP, S_U_EN, S_U_HOLD: begin
                LCD_RS   = r_rs;
                w_nibble = r_d[7:4];
            end
            S_GAP: LCD_RS = r_rs;
            S_L_SETUP, S_L_EN, S_L_HOLD: begin
                LCD_RS   = r_rs;
                w_nibble = r_d[3:0];
            end
            default: begin
                LCD_RS   = 1'b0;
                w_nibble = 4'b0000;
            end
        endcase
        {SF_D11, SF_D10, SF_D9, SF_D8} = w_nibble;
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// tb/tb_lcd_nibble_writer.sv - scoreboard bench for lcd_nibble_writer with a cycle-timeline reference model
module tb_lcd_nibble_writer;

    localparam int TS = 2;
    localparam int TE = 12;
    localparam int TH = 1;
    localparam int TG = 50;
    localparam int TSHORT = 300;
    localparam int TLONG  = 1500;
    localparam int P = TS + TE + TH;
    localparam int LAT_MAX = 2 * P + TG + TLONG + 1;

    typedef struct {
        logic       rs;
        logic [7:0] d;
    } cmd_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready, done, lcd_e, lcd_rs, lcd_rw;
    logic       sf_d11, sf_d10, sf_d9, sf_d8;

    lcd_nibble_writer #(
        .T_SETUP(TS), .T_E(TE), .T_HOLD(TH), .T_GAP(TG), .T_SHORT(TSHORT), .T_LONG(TLONG)
    ) dut (
        .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .done(done),
        .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
        .SF_D11(sf_d11), .SF_D10(sf_d10), .SF_D9(sf_d9), .SF_D8(sf_d8)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_accepted = 0;
    cmd_t exp_q[$];
    cmd_t cur;
    bit   busy = 0;
    bit   acc_pending = 0;
    bit   chk_en = 0;
    int   k = 0;

    function automatic int wait_len(input cmd_t c);
        if (!c.rs && c.d >= 8'd1 && c.d <= 8'd3) return TLONG;
        return TSHORT;
    endfunction

    function automatic int done_cycle(input cmd_t c);
        return 2 * P + TG + wait_len(c) + 1;
    endfunction

    // Expected {E, RS, RW, D[11:8], ready, done} at cycle kk after an accept edge.
    function automatic logic [8:0] model_out(input bit b, input int kk, input cmd_t c);
        int j;
        logic e, rs, rdy, dn;
        logic [3:0] nib;
        e = 0; rs = 0; nib = 4'h0; rdy = 0; dn = 0;
        if (!b) begin
            rdy = 1;
        end else if (kk >= 1 && kk <= P) begin
            rs = c.rs; nib = c.d[7:4]; e = (kk > TS && kk <= TS + TE);
        end else if (kk > P && kk <= P + TG) begin
            rs = c.rs;
        end else if (kk > P + TG && kk <= 2 * P + TG) begin
            j = kk - (P + TG);
            rs = c.rs; nib = c.d[3:0]; e = (j > TS && j <= TS + TE);
        end else if (kk == done_cycle(c)) begin
            rdy = 1; dn = 1;
        end
        return {e, rs, 1'b0, nib, rdy, dn};
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            chk_en = 1;
            busy = 0;
            acc_pending = 0;
        end else if (cmd_valid && (!busy || k == done_cycle(cur))) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected accept: no command pending, cmd_data=%h", cmd_data);
            end else begin
                cur = exp_q.pop_front();
                acc_pending = 1;
                n_accepted++;
            end
        end else if (busy && k == done_cycle(cur)) begin
            busy = 0;
        end
    end

    always @(negedge clk) begin
        logic [8:0] got, exp;
        if (acc_pending) begin
            busy = 1; k = 1; acc_pending = 0;
        end else if (busy) begin
            k++;
        end
        if (chk_en && n_fail < 30) begin
            got = {lcd_e, lcd_rs, lcd_rw, sf_d11, sf_d10, sf_d9, sf_d8, cmd_ready, done};
            exp = model_out(busy, k, cur);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL outputs busy=%0d cycle=%0d cmd=%b_%h: got %b required %b (E RS RW D ready done)",
                         busy, k, cur.rs, cur.d, got, exp);
            end
        end
    end

    task automatic offer(input logic [9:0] w, input bit keep_valid);
        int start;
        bit ok;
        exp_q.push_back('{rs: w[9], d: w[7:0]});
        cmd_data = w;
        cmd_valid = 1'b1;
        start = n_accepted;
        ok = 0;
        for (int c = 0; c < LAT_MAX + 10; c++) begin
            @(negedge clk);
            if (n_accepted != start) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL accept timeout: cmd %h not accepted, got 0 accepts required 1", w);
            void'(exp_q.pop_front());
        end
        if (!keep_valid) begin
            cmd_valid = 1'b0;
            cmd_data = 10'($urandom);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int c = 0; c < LAT_MAX + 10; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL idle timeout: model still busy at cycle %0d, required idle", k);
        end
    endtask

    initial begin
        logic [9:0] w;
        reset = 1'b0;
        cmd_valid = 1'b1;
        cmd_data = 10'h241;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);

        offer(10'h241, 0);
        wait_idle();
        offer(10'h001, 0);
        wait_idle();

        offer(10'h028, 0);
        offer(10'h20C, 0);
        wait_idle();

        offer(10'h2AB, 0);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (LAT_MAX + 20) @(negedge clk);

        offer(10'h000, 0);
        wait_idle();

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0)
                w = {1'b0, 1'($urandom), 6'd0, 2'($urandom)};
            else
                w = 10'($urandom);
            offer(w, 0);
            if ($urandom_range(0, 1) == 1) begin
                wait_idle();
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_nibble_writer.md
# lcd_nibble_writer

Downstream transmit stage of the character-LCD driver. It accepts one 10-bit LCD command/data word from the sequencing FSM over a valid/ready handshake and drives the 4-bit LCD bus. Each word goes out as two enable-strobed nibbles, upper nibble first, with controller-compliant setup, pulse, hold and gap timing. The block then holds off for the controller execution time before it reports completion. It is the single owner of LCD_E, LCD_RS, LCD_RW and SF_D8..SF_D11 once power-on initialisation is complete.

## Interface
Parameters:
- T_SETUP, 2: cycles RS/data are stable before E rises (40 ns at 50 MHz).
- T_E, 12: cycles E stays high (240 ns).
- T_HOLD, 1: cycles RS/data are held after E falls.
- T_GAP, 50: idle cycles between the two nibbles (1 µs).
- T_SHORT, 2000: post-write wait for normal commands and data (40 µs).
- T_LONG, 82000: post-write wait for clear and home (1.64 ms).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- cmd_data  in  10  {RS, RW, D[7:0]}. Bit 8 (RW) is ignored because the block is write-only.
- cmd_valid  in  1  a command is offered.
- cmd_ready  out  1  the block can accept a command.
- done  out  1  one-cycle pulse when the post-write wait ends.
- LCD_E, LCD_RS, LCD_RW  out  1 each  LCD control lines.
- SF_D11, SF_D10, SF_D9, SF_D8  out  1 each  LCD data nibble, MSB first.

## Operation
- Reset (reset==0 at a clock edge) forces state IDLE and clears the counter and the latched command. All outputs are 0 except cmd_ready, which is 1.
- A command is accepted when cmd_valid && cmd_ready at a rising edge. cmd_data is latched at that edge and is not sampled again.
- States: IDLE → U_SETUP → U_EN → U_HOLD → GAP → L_SETUP → L_EN → L_HOLD → WAIT → IDLE.
- Each timed state lasts exactly its parameter count of cycles. One 17-bit down-counter is shared by all timed states and reloaded on every state entry.
- LCD_RS equals latched bit 9 from U_SETUP through L_HOLD and is 0 in all other states.
- SF_D[11:8] carries latched D[7:4] in U_SETUP/U_EN/U_HOLD and latched D[3:0] in L_SETUP/L_EN/L_HOLD. It is 0000 in all other states.
- LCD_E is 1 only in U_EN and L_EN.
- LCD_RW is 0 at all times.
- WAIT length is T_LONG when the latched RS==0, D[7:2]==0 and D[1:0]!=0 (clear display 0x01, return home 0x02/0x03). It is T_SHORT otherwise, including for 0x00.
- cmd_ready is 1 only in IDLE. cmd_valid in any other state is ignored and has no side effects.
- done is 1 for the single cycle after WAIT expires. That cycle is IDLE with cmd_ready=1, so a new command can be accepted in the same cycle.
- Reset asserted in any state, including mid-E, returns the block to IDLE on that edge. LCD_E drops to 0 the same edge and no done is produced.

## Timing
- Cycle 0 is the accept edge.
- Upper nibble:
  - U_SETUP: cycles 1–2.
  - E high: cycles 3–14.
  - U_HOLD: cycle 15.
  - GAP: cycles 16–65.
- Lower nibble:
  - L_SETUP: cycles 66–67.
  - E high: cycles 68–79.
  - L_HOLD: cycle 80.
- WAIT: cycles 81–2080 (short) or 81–82080 (long).
- done and cmd_ready both go high in cycle 2081 (short) or 82081 (long).
- Accept-to-done latency with default parameters is 2081 or 82081 cycles. In general it is 2·(T_SETUP+T_E+T_HOLD)+T_GAP+T_wait+1.
- Throughput for back-to-back commands is one command per latency period with zero idle cycles.
- RS and SF_D never change in a cycle where LCD_E is 1 or in the T_HOLD cycle after it.

## Test plan
- Reset: hold reset=0 for 3 cycles with cmd_valid=1 → all LCD outputs are 0, cmd_ready=1 and done=0. No command is accepted during or because of reset.
- Data write 0x241 ('A', RS=1): SF_D=0100 with E=1 in cycles 3–14 and SF_D=0001 with E=1 in cycles 68–79. RS=1 in cycles 1–80. done pulses in cycle 2081 only.
- Clear 0x001: nibbles 0000 then 0001, E pulses as above, RS=0 throughout. done is in cycle 82081, not 2081.
- Busy protection: accept 0x028, then drive cmd_valid=1 with cmd_data=0x20C continuously. Lower nibble is 1000 (not 1100). The second command is accepted exactly in the done cycle 2081 and its E pulses start at cycle 2084.
- Reset mid-operation: assert reset in cycle 8 (inside U_EN) → LCD_E=0 and cmd_ready=1 from cycle 9. No done appears within the next 90000 cycles.
- Boundary code 0x000 (RS=0, D=0): WAIT is T_SHORT and done occurs in cycle 2081.
